// File: rtl/cmd_sequencer.sv
// cmd_sequencer: program counter, instruction decode and call stack.
// Runs EXEC/JUMP/JZ/CALL/RET/HALT beats and reports stack and opcode faults.
module cmd_sequencer #(
  parameter int          ADDR_W   = 4,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  localparam int         INSTR_W  = 4 + ADDR_W,
  localparam int         SP_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               cond_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               exec_valid_o,
  output logic [ADDR_W-1:0]  exec_data_o,
  output logic [SP_W-1:0]    sp_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic [1:0]         fault_code_o
);

  // Stack storage is sized to a power of two so the index never
  // needs a range check; only the first DEPTH slots are ever used.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] OP_EXEC = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_CALL = 4'h8;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OVER  = 2'b01;
  localparam logic [1:0] FC_UNDER = 2'b10;
  localparam logic [1:0] FC_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED,
    S_FAULT
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [SP_W-1:0]     sp_q;
  logic                ready_q;
  logic                halted_q;
  logic                fault_q;
  logic [1:0]          fc_q;
  logic                exv_q;
  logic [ADDR_W-1:0]   exd_q;
  logic [ADDR_W-1:0]   stack_q [2**IDX_W];

  logic [3:0]          op;
  logic [ADDR_W-1:0]   operand;
  logic [ADDR_W-1:0]   pc_inc_d;
  logic                full;
  logic                empty;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    pop_idx;
  logic                push_en;

  assign op       = instr_i[INSTR_W-1 -: 4];
  assign operand  = instr_i[ADDR_W-1:0];
  assign pc_inc_d = pc_q + ADDR_W'(1);
  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = push_idx - IDX_W'(1);
  assign push_en  = (state_q == S_RUN) && instr_valid_i
                  && (op == OP_CALL) && !full;

  // Return-address storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc_d;
  end

  // Control FSM with pc, stack pointer and all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= ADDR_W'(RESET_PC);
      sp_q     <= '0;
      ready_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      fc_q     <= FC_NONE;
      exv_q    <= 1'b0;
      exd_q    <= '0;
    end else begin
      exv_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (instr_valid_i) begin
            case (op)
              OP_EXEC: begin
                exv_q <= 1'b1;
                exd_q <= operand;
                pc_q  <= pc_inc_d;
              end
              OP_JUMP: pc_q <= operand;
              OP_JZ:   pc_q <= cond_i ? pc_inc_d : operand;
              OP_CALL: begin
                if (full) begin
                  state_q <= S_FAULT;
                  ready_q <= 1'b0;
                  fault_q <= 1'b1;
                  fc_q    <= FC_OVER;
                end else begin
                  pc_q <= operand;
                  sp_q <= sp_q + SP_W'(1);
                end
              end
              OP_RET: begin
                if (empty) begin
                  state_q <= S_FAULT;
                  ready_q <= 1'b0;
                  fault_q <= 1'b1;
                  fc_q    <= FC_UNDER;
                end else begin
                  pc_q <= stack_q[pop_idx];
                  sp_q <= sp_q - SP_W'(1);
                end
              end
              OP_HALT: begin
                state_q  <= S_HALTED;
                ready_q  <= 1'b0;
                halted_q <= 1'b1;
              end
              default: begin
                state_q <= S_FAULT;
                ready_q <= 1'b0;
                fault_q <= 1'b1;
                fc_q    <= FC_ILL;
              end
            endcase
          end
        end
        S_HALTED, S_FAULT: begin
          if (clear_i) begin
            state_q  <= S_IDLE;
            pc_q     <= ADDR_W'(RESET_PC);
            sp_q     <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            fc_q     <= FC_NONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign pc_o          = pc_q;
  assign exec_valid_o  = exv_q;
  assign exec_data_o   = exd_q;
  assign sp_o          = sp_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;
  assign fault_code_o  = fc_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: queue-based reference model compared every
// cycle, plus directed beats with hand-computed literal expectations.
module tb_cmd_sequencer;

  localparam int AW  = 4;
  localparam int DEP = 4;
  localparam int IW  = 4 + AW;
  localparam int SPW = $clog2(DEP + 1);
  localparam int MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          cond = 1'b0;
  logic [IW-1:0] instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [AW-1:0] pc;
  logic          exec_valid;
  logic [AW-1:0] exec_data;
  logic [SPW-1:0] sp;
  logic          halted;
  logic          fault;
  logic [1:0]    fault_code;

  int checks = 0;
  int failures = 0;

  cmd_sequencer #(.ADDR_W(AW), .DEPTH(DEP), .RESET_PC(0)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .clear_i(clear),
    .cond_i(cond),
    .instr_i(instr),
    .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready),
    .pc_o(pc),
    .exec_valid_o(exec_valid),
    .exec_data_o(exec_data),
    .sp_o(sp),
    .halted_o(halted),
    .fault_o(fault),
    .fault_code_o(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 run, 2 halted, 3 fault.
  int m_mode;
  int m_pc;
  int m_stk[$];
  int m_exv;
  int m_exd;
  int m_fc;
  int m_op;
  int m_opd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = 0; m_stk.delete();
      m_exv = 0; m_exd = 0; m_fc = 0;
    end else begin
      m_exv = 0;
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (instr_valid) begin
          m_op  = int'(instr) / MOD;
          m_opd = int'(instr) % MOD;
          if (m_op == 0) begin
            m_exv = 1; m_exd = m_opd; m_pc = (m_pc + 1) % MOD;
          end else if (m_op == 4) begin
            m_pc = m_opd;
          end else if (m_op == 6) begin
            m_pc = cond ? (m_pc + 1) % MOD : m_opd;
          end else if (m_op == 8) begin
            if (m_stk.size() == DEP) begin
              m_mode = 3; m_fc = 1;
            end else begin
              m_stk.push_back((m_pc + 1) % MOD); m_pc = m_opd;
            end
          end else if (m_op == 12) begin
            if (m_stk.size() == 0) begin
              m_mode = 3; m_fc = 2;
            end else begin
              m_pc = m_stk.pop_back();
            end
          end else if (m_op == 15) begin
            m_mode = 2;
          end else begin
            m_mode = 3; m_fc = 3;
          end
        end
      end else begin
        if (clear) begin
          m_mode = 0; m_pc = 0; m_stk.delete(); m_fc = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_ready", int'(instr_ready), int'(m_mode == 1));
    chk("m_pc", int'(pc), m_pc);
    chk("m_exec_valid", int'(exec_valid), m_exv);
    chk("m_exec_data", int'(exec_data), m_exd);
    chk("m_sp", int'(sp), m_stk.size());
    chk("m_halted", int'(halted), int'(m_mode == 2));
    chk("m_fault", int'(fault), int'(m_mode == 3));
    chk("m_fault_code", int'(fault_code), m_fc);
  end

  task automatic beat(input logic v, input logic [IW-1:0] ins,
                      input logic c);
    instr_valid = v; instr = ins; cond = c;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_sp", int'(sp), 0);
    chk("rst_ready", int'(instr_ready), 0);
    rst = 1'b0;

    do_start();
    chk("start_ready", int'(instr_ready), 1);

    beat(1, 8'h03, 0);
    chk("exec_valid", int'(exec_valid), 1);
    chk("exec_data", int'(exec_data), 3);
    chk("exec_pc", int'(pc), 1);
    beat(1, 8'h05, 0);
    chk("exec2_pc", int'(pc), 2);
    beat(0, 8'h00, 0);
    chk("idle_pc", int'(pc), 2);
    chk("idle_exv", int'(exec_valid), 0);

    beat(1, 8'h89, 0);
    chk("call_pc", int'(pc), 9);
    chk("call_sp", int'(sp), 1);
    beat(0, 8'h00, 0);
    chk("hold_pc", int'(pc), 9);
    beat(1, 8'hC0, 0);
    chk("ret_pc", int'(pc), 3);
    chk("ret_sp", int'(sp), 0);

    beat(1, 8'h6A, 0);
    chk("jz0_pc", int'(pc), 10);
    beat(1, 8'h6A, 1);
    chk("jz1_pc", int'(pc), 11);
    beat(1, 8'h4F, 0);
    chk("jump_pc", int'(pc), 15);
    beat(1, 8'h01, 0);
    chk("wrap_pc", int'(pc), 0);

    beat(1, 8'h4F, 0);
    beat(1, 8'h82, 0);
    chk("callF_pc", int'(pc), 2);
    beat(1, 8'hC0, 0);
    chk("retF_pc", int'(pc), 0);

    beat(1, 8'h85, 0);
    beat(1, 8'h8A, 0);
    beat(1, 8'hC0, 0);
    chk("lifo1_pc", int'(pc), 6);
    beat(1, 8'hC0, 0);
    chk("lifo2_pc", int'(pc), 1);

    beat(1, 8'h85, 0);
    beat(1, 8'h8A, 0);
    beat(1, 8'h83, 0);
    beat(1, 8'h8D, 0);
    chk("full_sp", int'(sp), 4);
    beat(1, 8'h81, 0);
    chk("ovf_fault", int'(fault), 1);
    chk("ovf_code", int'(fault_code), 1);
    chk("ovf_sp", int'(sp), 4);
    chk("ovf_pc", int'(pc), 13);
    chk("ovf_ready", int'(instr_ready), 0);
    beat(1, 8'h03, 0);
    chk("ovf_ignore_pc", int'(pc), 13);

    start = 1'b1;
    do_clear();
    start = 1'b0;
    chk("clr_ready", int'(instr_ready), 0);
    chk("clr_pc", int'(pc), 0);
    chk("clr_sp", int'(sp), 0);

    do_start();
    beat(1, 8'hC0, 0);
    chk("udf_code", int'(fault_code), 2);
    chk("udf_ready", int'(instr_ready), 0);
    do_clear();
    do_start();
    beat(1, 8'h30, 0);
    chk("ill_code", int'(fault_code), 3);
    chk("ill_ready", int'(instr_ready), 0);
    do_clear();
    do_start();

    beat(1, 8'h03, 0);
    beat(1, 8'hF0, 0);
    chk("halt_halted", int'(halted), 1);
    chk("halt_pc", int'(pc), 1);
    beat(1, 8'h05, 0);
    chk("halt_ignore_pc", int'(pc), 1);
    chk("halt_ignore_exd", int'(exec_data), 3);
    do_clear();

    do_start();
    beat(1, 8'h85, 0);
    instr_valid = 1'b1; instr = 8'h8A;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pc", int'(pc), 0);
    chk("arst_sp", int'(sp), 0);
    chk("arst_ready", int'(instr_ready), 0);
    chk("arst_exd", int'(exec_data), 0);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Parametrised command sequencer: holds the program counter, decodes one instruction packet per accepted beat, executes EXECUTE/JUMP/conditional JUMP/CALL/RETURN/HALT, and keeps return addresses on an internal call stack of configurable depth. It sits between instruction memory, which it addresses through `pc`, and the execution datapath, which receives the EXECUTE operands. Compared with the earlier decoder it adds a valid/ready handshake, full and empty detection on the stack, a conditional jump, a halt state and fault reporting.

## Interface
- `ADDR_W`, 4: PC and stack-entry width; address space is 2^ADDR_W.
- `DEPTH`, 4: call-stack entries; must be at least 1.
- `RESET_PC`, 0: PC value loaded on reset and on `clear`.
- Instruction width `INSTR_W` = 4 + ADDR_W, laid out as {op[3:0], operand[ADDR_W-1:0]}.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  leave IDLE and enter RUN.
- `clear`  in  1  synchronous return from HALTED/FAULT to IDLE; PC returns to RESET_PC and the stack is emptied.
- `cond`  in  1  condition flag, sampled only for JZ.
- `instr`  in  INSTR_W  instruction packet, read from `pc`.
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  block accepts `instr` this cycle.
- `pc`  out  ADDR_W  current fetch address.
- `exec_valid`  out  1  one-cycle pulse: `exec_data` is valid.
- `exec_data`  out  ADDR_W  operand of the last accepted EXECUTE.
- `sp`  out  clog2(DEPTH+1)  current stack occupancy, 0..DEPTH.
- `halted`  out  1  state is HALTED.
- `fault`  out  1  state is FAULT.
- `fault_code`  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 illegal opcode.

## Operation
- States: IDLE, RUN, HALTED, FAULT.
- Transitions: IDLE→RUN on `start`; RUN→HALTED on HALT; RUN→FAULT on a fault; HALTED/FAULT→IDLE on `clear`.
- `instr_ready` = (state==RUN). An instruction is accepted when `instr_valid && instr_ready`.
- Opcodes, applied on an accepted beat:
  - 4'h0 EXEC: pulse `exec_valid`, `exec_data`=operand, pc←pc+1.
  - 4'h4 JUMP: pc←operand.
  - 4'h6 JZ: pc←operand if `cond`==0, else pc+1.
  - 4'h8 CALL: push pc+1, pc←operand, sp+1.
  - 4'hC RET: pop, pc←top entry, sp−1.
  - 4'hF HALT: pc unchanged, go to HALTED.
  - Any other opcode: illegal; fault_code 11, go to FAULT, pc unchanged.
- CALL with sp==DEPTH: no push, pc unchanged, fault_code 01, go to FAULT.
- RET with sp==0: no pop, pc unchanged, fault_code 10, go to FAULT.
- PC arithmetic is modulo 2^ADDR_W: pc+1 from all-ones wraps to 0. This applies both to the pushed return address and to EXEC.
- No valid beat while in RUN: pc and stack hold.
- `fault_code` holds its value until `clear` or `rst`. Only the first fault is recorded.
- `start` is ignored outside IDLE. `clear` is ignored in IDLE and RUN.
- If `start` and `clear` are both asserted in HALTED/FAULT, `clear` wins and the block stays in IDLE for that edge.

## Timing
- All state updates happen on the `clk` rising edge. No combinational path from `instr` to `pc`.
- Throughput is one instruction per cycle. The new `pc` is visible the cycle after acceptance.
- `exec_valid`/`exec_data` are registered: high for exactly the cycle after an EXEC is accepted.
- After `start`, `instr_ready` rises the next cycle.
- The transition to HALTED/FAULT takes effect the cycle after acceptance, so `instr_ready` drops that cycle.
- Reset values: pc=RESET_PC, sp=0, state IDLE, instr_ready=0, exec_valid=0, exec_data=0, halted=0, fault=0, fault_code=00.
- Stack memory contents are not reset.
- `rst` asserted mid-operation aborts immediately: the in-flight beat is discarded and the stack is emptied.

## Test plan
- Reset, start, then EXEC 0x3 at pc 0 → exec_valid pulse with exec_data=3, pc=1; back-to-back EXECs advance pc once per cycle.
- CALL 0x9 at pc 2, then RET at 9 → pc=9 with sp=1, then pc=3 with sp=0; nested calls to DEPTH work and return in LIFO order.
- With DEPTH=4: five nested CALLs → fault=1, fault_code=01, sp=4, pc held; `clear` → IDLE, pc=RESET_PC, sp=0.
- RET with an empty stack → fault_code=10; opcode 4'h3 → fault_code=11; in both cases instr_ready=0 the next cycle.
- JZ 0xA with cond=0 → pc=A; with cond=1 → pc=pc+1. EXEC at pc=0xF with ADDR_W=4 → pc wraps to 0. CALL at 0xF pushes 0.
- instr_valid toggling every other cycle → pc holds on idle cycles. HALT → halted=1, later instructions ignored. rst mid-CALL sequence → all reset values.
